// File: rtl/adder_arb_pkg.sv
// Shared types and widths for the two-requester burst adder arbiter.
package adder_arb_pkg;

  localparam int unsigned REQ_W = 8;
  localparam int unsigned NREQ  = 2;

  typedef enum logic {
    StIdle,
    StBurst
  } arb_state_e;

endpackage

// File: rtl/adder_burst_arbiter_if.sv
// Requester-side byte streams and result stream of the burst adder arbiter.
interface adder_burst_arbiter_if;
  import adder_arb_pkg::*;

  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [REQ_W-1:0] req_a0;
  logic [REQ_W-1:0] req_b0;
  logic [REQ_W-1:0] req_a1;
  logic [REQ_W-1:0] req_b1;
  logic [NREQ-1:0]  req_cin;
  logic [NREQ-1:0]  req_last;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [REQ_W-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_id;
  logic             rsp_last;
  logic             rsp_err;

  // Requesters and result consumer.
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_cin, req_last, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last, rsp_err
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_cin, req_last, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last, rsp_err
  );

endinterface

// File: rtl/tt_um_parallel_adder.sv
// Shared 8-bit parallel adder: ui_in1 + ui_in2 + ui_in3 -> {uo_out2, uo_out1}.
module tt_um_parallel_adder
  import adder_arb_pkg::*;
(
  input  logic [REQ_W-1:0] ui_in1,
  input  logic [REQ_W-1:0] ui_in2,
  input  logic             ui_in3,
  output logic [REQ_W-1:0] uo_out1,
  output logic             uo_out2
);

  logic [REQ_W:0] full_sum;

  // Widen by one bit so the carry-out falls out of the MSB.
  always_comb begin
    full_sum = {1'b0, ui_in1} + {1'b0, ui_in2} + {{REQ_W{1'b0}}, ui_in3};
  end

  assign uo_out1 = full_sum[REQ_W-1:0];
  assign uo_out2 = full_sum[REQ_W];

endmodule

// File: rtl/adder_burst_arbiter.sv
// Round-robin burst arbiter sharing one 8-bit adder between two requesters.
// Carry is chained across the beats of a burst; results leave through a
// one-deep registered output stage with backpressure.
module adder_burst_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_burst_arbiter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(MAX_BEATS);

  arb_state_e      state_q;
  logic            owner_q;
  logic            rr_q;
  logic            carry_q;
  logic [CntW-1:0] beat_cnt_q;

  logic             rsp_valid_q;
  logic [REQ_W-1:0] rsp_sum_q;
  logic             rsp_cout_q;
  logic             rsp_id_q;
  logic             rsp_last_q;
  logic             rsp_err_q;

  logic [NREQ-1:0]  req_ready;
  logic             stage_free;
  logic             accept;
  logic             own_last;
  logic             at_max;
  logic             burst_end;
  logic [REQ_W-1:0] a_sel;
  logic [REQ_W-1:0] b_sel;
  logic             cin_sel;
  logic [REQ_W-1:0] add_sum;
  logic             add_cout;

  // Handshake, operand mux and burst-end decode for the current owner.
  always_comb begin
    req_ready  = '0;
    stage_free = ~rsp_valid_q | bus.rsp_ready;
    if (state_q == StBurst) begin
      req_ready[owner_q] = stage_free;
    end
    accept    = (state_q == StBurst) & bus.req_valid[owner_q] & stage_free;
    own_last  = bus.req_last[owner_q];
    at_max    = (beat_cnt_q == CntW'(MAX_BEATS - 1));
    burst_end = own_last | at_max;
    a_sel     = owner_q ? bus.req_a1 : bus.req_a0;
    b_sel     = owner_q ? bus.req_b1 : bus.req_b0;
    // Requester carry-in only seeds the first beat; later beats chain.
    cin_sel   = (beat_cnt_q == '0) ? bus.req_cin[owner_q] : carry_q;
  end

  tt_um_parallel_adder u_adder (
    .ui_in1  (a_sel),
    .ui_in2  (b_sel),
    .ui_in3  (cin_sel),
    .uo_out1 (add_sum),
    .uo_out2 (add_cout)
  );

  // Arbitration FSM with round-robin pointer, carry chain and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      carry_q    <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|bus.req_valid) begin
            // Contention follows rr; a lone requester wins outright.
            owner_q <= (&bus.req_valid) ? rr_q : bus.req_valid[1];
            state_q <= StBurst;
          end
        end
        StBurst: begin
          if (accept) begin
            carry_q <= add_cout;
            if (burst_end) begin
              beat_cnt_q <= '0;
              rr_q       <= ~owner_q;
              state_q    <= StIdle;
            end else begin
              beat_cnt_q <= beat_cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // One-deep result register; loads on accept, empties when drained alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_sum_q   <= add_sum;
      rsp_cout_q  <= add_cout;
      rsp_id_q    <= owner_q;
      rsp_last_q  <= burst_end;
      // Error only when the length cap, not the requester, ended the burst.
      rsp_err_q   <= at_max & ~own_last;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
